// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the unified-memory arbiter.
// No logic of its own; pure type, constant and helper definitions.
// Used by mem_arbiter and rr_arb2.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC    = 2'd1,
    ST_RMW_WR = 2'd2
  } state_t;

  // LSU access sizes; 2'b11 is treated like a word
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Requester ids, also the bit index of each port in req/gnt vectors
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Byte and halfword sizes need a read-modify-write cycle
  function automatic logic is_sub_word(input logic [1:0] size);
    return !size[1];
  endfunction

  // Merge new store data into the old word; lane 0 always sits at addr,
  // so the new bytes are the low ones and no shifting is needed
  function automatic logic [31:0] rmw_merge(input logic [1:0]  size,
                                            input logic [31:0] old_word,
                                            input logic [31:0] wdata);
    if (size == SZ_B) return {old_word[31:8], wdata[7:0]};
    return {old_word[31:16], wdata[15:0]};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the port not granted last time.
// Combinational grant, zero latency; last_port moves only on a granted tie.
// No backpressure of its own: en gates all grants off while the owner is busy.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_port;

  // Grant a lone requester directly; break ties against the last winner
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last_port == PORT_IF) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the tie winner; reset favours fetch on the first tie
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_port <= PORT_LS;
    end else if (en && (req == 2'b11)) begin
      last_port <= ~last_port;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-addressed unified memory between fetch (port 0) and LSU (port 1).
// Grant to rvalid: 2 cycles for reads and word stores, 3 for byte/half stores.
// Requests are held until gnt; gnt is only given in IDLE, so a busy memory stalls requesters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  state_t                state_q, state_d;
  logic   [1:0]          gnt;
  logic                  arb_en;
  logic                  sel_ls;
  logic                  need_rmw;

  // Latched copy of the granted request
  logic                  port_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] pre_word_q;

  rr_arb2 u_arb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (arb_en),
    .req       ({ls_req, if_req}),
    .gnt       (gnt)
  );

  assign need_rmw = (port_q == PORT_LS) && we_q && is_sub_word(size_q);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state: one access cycle, plus a write-back cycle for sub-word stores
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|gnt) state_d = ST_ACC;
      ST_ACC:    state_d = need_rmw ? ST_RMW_WR : ST_IDLE;
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Grants are only offered while idle, straight from the arbiter
  always_comb begin
    arb_en = (state_q == ST_IDLE);
    if_gnt = gnt[PORT_IF];
    ls_gnt = gnt[PORT_LS];
    sel_ls = gnt[PORT_LS];
  end

  // Memory command, request latch and response registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem_op     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_data_w <= '0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      size_q     <= SZ_W;
      wdata_q    <= '0;
      pre_word_q <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            port_q     <= sel_ls;
            we_q       <= sel_ls && ls_we;
            size_q     <= ls_size;
            wdata_q    <= ls_wdata;
            mem_op     <= 1'b1;
            mem_addr   <= sel_ls ? ls_addr : if_addr;
            // Sub-word stores read first, so only a word store writes now
            mem_rw     <= sel_ls && ls_we && !is_sub_word(ls_size);
            mem_data_w <= sel_ls ? ls_wdata : '0;
          end
        end
        ST_ACC: begin
          if (need_rmw) begin
            pre_word_q <= mem_data_r;
            mem_data_w <= rmw_merge(size_q, mem_data_r, wdata_q);
            mem_rw     <= 1'b1;
            mem_op     <= 1'b1;
          end else begin
            mem_op <= 1'b0;
            mem_rw <= 1'b0;
            if (port_q == PORT_LS) begin
              ls_rdata  <= mem_data_r;
              ls_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_data_r;
              if_rvalid <= 1'b1;
            end
          end
        end
        ST_RMW_WR: begin
          mem_op    <= 1'b0;
          mem_rw    <= 1'b0;
          ls_rdata  <= pre_word_q;
          ls_rvalid <= 1'b1;
        end
        default: begin
          mem_op <= 1'b0;
          mem_rw <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'b10;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_op, mem_rw;
  logic [31:0] mem_addr, mem_data_w;
  logic [31:0] mem_data_r = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 1'b0;

  always #5 sys_clk = ~sys_clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_op(mem_op), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
  );

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Byte-addressed memory seen by the DUT: acts on the negedge, byte addr+i = lane i
  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  function automatic logic [11:0] bidx(input logic [31:0] a, input int i);
    logic [31:0] s;
    s = a + i;
    return s[11:0];
  endfunction

  always @(negedge sys_clk) begin
    if (mem_op) begin
      if (mem_rw) begin
        for (int i = 0; i < 4; i++) mem[bidx(mem_addr, i)] <= mem_data_w[8*i +: 8];
      end else begin
        mem_data_r <= {mem[bidx(mem_addr, 3)], mem[bidx(mem_addr, 2)],
                       mem[bidx(mem_addr, 1)], mem[bidx(mem_addr, 0)]};
      end
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return {ref_mem[bidx(a, 3)], ref_mem[bidx(a, 2)], ref_mem[bidx(a, 1)], ref_mem[bidx(a, 0)]};
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) ref_mem[bidx(a, i)] = d[8*i +: 8];
  endtask

  // Sets a word in both the DUT-side memory and the reference image
  task automatic preset_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) mem[bidx(a, i)] = d[8*i +: 8];
    ref_wr(a, d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  // Transaction-level reference: one outstanding access, outputs derived from its age
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  bit          m_port, m_we, m_sub, m_known;
  logic [31:0] m_addr, m_wdata, m_resp, m_merge, m_old;
  int          m_gcyc, m_due;
  logic [31:0] e_if_rd = '0, e_ls_rd = '0;
  bit          e_ls_known = 1'b1;
  bit          e_ifg, e_lsg, e_ifv, e_lsv, e_op, e_rw;
  logic [31:0] e_addr, e_dw, a_ls_rd;
  logic [133:0] act_v, exp_v;

  always @(negedge sys_clk) begin
    if (model_on) begin
      e_ifv = 0; e_lsv = 0; e_op = 0; e_rw = 0; e_addr = '0; e_dw = '0;
      if (!sys_rst_n) begin
        m_busy = 0; m_last = 1'b1; e_if_rd = '0; e_ls_rd = '0; e_ls_known = 1'b1;
      end else if (m_busy) begin
        if (cyc == m_due) begin
          if (m_port) begin e_lsv = 1; e_ls_rd = m_resp; e_ls_known = m_known; end
          else begin e_ifv = 1; e_if_rd = m_resp; end
          m_busy = 0;
        end else if (cyc > m_gcyc) begin
          e_op = 1; e_addr = m_addr;
          if (m_port && m_we) begin
            if (!m_sub) begin e_rw = 1; e_dw = m_wdata; end
            else if (cyc == m_gcyc + 2) begin e_rw = 1; e_dw = m_merge; end
          end
        end
      end
      e_ifg = 0; e_lsg = 0;
      if (!m_busy) begin
        if (if_req && ls_req) begin
          if (m_last) e_ifg = 1; else e_lsg = 1;
        end else begin
          e_ifg = if_req; e_lsg = ls_req;
        end
      end
      a_ls_rd = e_ls_known ? ls_rdata : e_ls_rd;
      act_v = {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata, a_ls_rd, mem_op,
               mem_op & mem_rw, (mem_op ? mem_addr : 32'h0), ((mem_op & mem_rw) ? mem_data_w : 32'h0)};
      exp_v = {e_ifg, e_lsg, e_ifv, e_lsv, e_if_rd, e_ls_rd, e_op, e_rw, e_addr, e_dw};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model cyc=%0d got=%h expected=%h", cyc, act_v, exp_v);
      end
      if (sys_rst_n && (e_ifg || e_lsg)) begin
        if (if_req && ls_req) m_last = e_lsg;
        m_port  = e_lsg;
        m_we    = e_lsg && ls_we;
        m_sub   = m_we && (ls_size == 2'b00 || ls_size == 2'b01);
        m_addr  = e_lsg ? ls_addr : if_addr;
        m_wdata = ls_wdata;
        m_old   = ref_rd(m_addr);
        m_resp  = m_old;
        m_known = !(m_we && !m_sub);
        if (m_we) begin
          if (m_sub) begin
            m_merge = (ls_size == 2'b00) ? {m_old[31:8], ls_wdata[7:0]} : {m_old[31:16], ls_wdata[15:0]};
            ref_wr(m_addr, m_merge);
          end else begin
            ref_wr(m_addr, ls_wdata);
          end
        end
        m_gcyc = cyc;
        m_due  = cyc + (m_sub ? 3 : 2);
        m_busy = 1;
      end
    end
  end

  // One request on one port; reports response data, grant-to-rvalid latency and mem_op/rw cycles
  task automatic txn(input bit port, input bit we, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output int lat,
                     output int opc, output int rwc);
    int g;
    bit got;
    rd = '0; lat = -1; opc = 0; rwc = 0; g = 0;
    @(posedge sys_clk); #1;
    if (port) begin ls_req = 1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge sys_clk);
      if (port ? ls_gnt : if_gnt) begin got = 1; g = cyc; end
    end
    @(posedge sys_clk); #1;
    if_req = 0; ls_req = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL gnt_timeout port=%0d got=none expected=grant", port);
      return;
    end
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge sys_clk);
      if (mem_op) opc++;
      if (mem_op && mem_rw) rwc++;
      if (port ? ls_rvalid : if_rvalid) begin
        got = 1; lat = cyc - g; rd = port ? ls_rdata : if_rdata;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout port=%0d got=none expected=rvalid", port);
    end
  endtask

  logic [31:0] rd;
  int lat, opc, rwc;
  int gp[$];
  int gc[$];
  bit got;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    preset_word(32'h0, 32'hf0000537);
    model_on = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_mem_op", {31'h0, mem_op}, 32'h0);
    chk("reset_ls_rdata", ls_rdata, 32'h0);
    sys_rst_n = 1'b1;

    // Both ports requesting continuously: IF first, then strict alternation
    @(posedge sys_clk); #1;
    if_req = 1; if_addr = 32'h0;
    ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h100;
    for (int k = 0; k < 9; k++) begin
      @(negedge sys_clk);
      if (if_gnt) begin gp.push_back(0); gc.push_back(cyc); end
      if (ls_gnt) begin gp.push_back(1); gc.push_back(cyc); end
    end
    @(posedge sys_clk); #1;
    if_req = 0; ls_req = 0;
    repeat (4) @(posedge sys_clk);
    if (gp.size() < 4) begin
      checks++; errors++;
      $display("FAIL contention_grants got=%0d expected=4+", gp.size());
    end else begin
      chk("contention_g0", gp[0], 0);
      chk("contention_g1", gp[1], 1);
      chk("contention_g2", gp[2], 0);
      chk("contention_g3", gp[3], 1);
      for (int i = 0; i < 3; i++) chk("contention_spacing", gc[i+1] - gc[i], 2);
    end

    // Fetch only
    txn(0, 0, 2'b10, 32'h0, 32'h0, rd, lat, opc, rwc);
    chk("fetch_rdata", rd, 32'hf0000537);
    chk("fetch_latency", lat, 2);
    chk("fetch_op_cycles", opc, 1);

    // Word store then load
    txn(1, 1, 2'b10, 32'h100, 32'h12345678, rd, lat, opc, rwc);
    chk("wstore_latency", lat, 2);
    chk("wstore_rw_cycles", rwc, 1);
    txn(1, 0, 2'b10, 32'h100, 32'h0, rd, lat, opc, rwc);
    chk("wload_rdata", rd, 32'h12345678);
    chk("wload_latency", lat, 2);

    // Byte store into a preset word
    preset_word(32'h100, 32'haabbccdd);
    txn(1, 1, 2'b00, 32'h100, 32'h000000ee, rd, lat, opc, rwc);
    chk("bstore_latency", lat, 3);
    chk("bstore_op_cycles", opc, 2);
    chk("bstore_rw_cycles", rwc, 1);
    chk("bstore_preword", rd, 32'haabbccdd);
    txn(1, 0, 2'b10, 32'h100, 32'h0, rd, lat, opc, rwc);
    chk("bstore_readback", rd, 32'haabbccee);

    // Half stores: at 0x102 the low half of the written word lands on bytes 0x102..0x103
    txn(1, 1, 2'b10, 32'h100, 32'h12345678, rd, lat, opc, rwc);
    txn(1, 1, 2'b01, 32'h102, 32'h00001234, rd, lat, opc, rwc);
    chk("hstore_latency", lat, 3);
    chk("hstore_preword", rd, 32'h00001234);
    txn(1, 0, 2'b10, 32'h100, 32'h0, rd, lat, opc, rwc);
    chk("hstore_read_100", rd, 32'h12345678);
    txn(1, 0, 2'b10, 32'h102, 32'h0, rd, lat, opc, rwc);
    chk("hstore_read_102", rd, 32'h00001234);
    txn(1, 1, 2'b01, 32'h100, 32'h0000beef, rd, lat, opc, rwc);
    txn(1, 0, 2'b10, 32'h100, 32'h0, rd, lat, opc, rwc);
    chk("hstore_read_merge", rd, 32'h1234beef);

    // Reset while a load sits in the access cycle
    @(posedge sys_clk); #1;
    ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h100;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge sys_clk);
      if (ls_gnt) got = 1;
    end
    @(posedge sys_clk); #1;
    ls_req = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL rst_gnt_timeout got=none expected=grant");
    end
    #1 sys_rst_n = 1'b0;
    #1 chk("rst_mid_mem_op", {31'h0, mem_op}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk("rst_mid_no_rvalid", {31'h0, ls_rvalid}, 32'h0);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    txn(1, 0, 2'b10, 32'h100, 32'h0, rd, lat, opc, rwc);
    chk("rst_reissue_rdata", rd, 32'h1234beef);
    chk("rst_reissue_latency", lat, 2);

    repeat (3) @(posedge sys_clk);
    #1;
    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
